// File: rtl/countdown_timer.sv
// countdown_timer: egg-timer main countdown, four BCD digits mm:ss (00:00-99:59).
// Loads clamped setting digits on load_timer and counts down once per sec_pulse while enabled.
//
// Ports:
//   clk, reset (async, active-high)
//   sec_pulse         : one-clk strobe per second
//   load_timer        : load set_* digits into the count
//   main_timer_enable : level, permits decrementing
//   set_min_tens/set_min_ones/set_sec_tens/set_sec_ones : BCD setting digits
//   min_tens/min_ones/sec_tens/sec_ones : registered remaining time
//   timer_done        : high whenever the count is 00:00
//   done_pulse        : one-cycle strobe when a countdown reaches 00:00
//   alarm             : expiry alarm level
//
// Optional feature: define COUNTDOWN_ALARM_EN to build the expiry alarm,
// which stays high for ALARM_SECONDS sec_pulse ticks. Otherwise alarm is 0.
module countdown_timer #(
    parameter int ALARM_SECONDS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_pulse,
    input  logic       load_timer,
    input  logic       main_timer_enable,
    input  logic [3:0] set_min_tens,
    input  logic [3:0] set_min_ones,
    input  logic [3:0] set_sec_tens,
    input  logic [3:0] set_sec_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       done_pulse,
    output logic       alarm
);

    typedef enum logic [1:0] {
        ZERO    = 2'd0,
        PAUSED  = 2'd1,
        RUNNING = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [3:0] min_tens_n, min_ones_n, sec_tens_n, sec_ones_n;
    logic       done_pulse_n;

    // Clamped load values
    logic [3:0] ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones;
    logic       ld_zero;

    // One-second decrement with BCD borrow chain
    logic [3:0] dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones;
    logic       borrow0, borrow1, borrow2;
    logic       dec_zero;

    always_comb begin
        ld_min_tens = (set_min_tens > 4'd9) ? 4'd9 : set_min_tens;
        ld_min_ones = (set_min_ones > 4'd9) ? 4'd9 : set_min_ones;
        ld_sec_tens = (set_sec_tens > 4'd5) ? 4'd5 : set_sec_tens;
        ld_sec_ones = (set_sec_ones > 4'd9) ? 4'd9 : set_sec_ones;
        ld_zero     = ({ld_min_tens, ld_min_ones,
                        ld_sec_tens, ld_sec_ones} == 16'h0000);
    end

    always_comb begin
        borrow0      = (sec_ones == 4'd0);
        dec_sec_ones = borrow0 ? 4'd9 : sec_ones - 4'd1;

        borrow1      = borrow0 && (sec_tens == 4'd0);
        dec_sec_tens = sec_tens;
        if (borrow0)
            dec_sec_tens = (sec_tens == 4'd0) ? 4'd5 : sec_tens - 4'd1;

        borrow2      = borrow1 && (min_ones == 4'd0);
        dec_min_ones = min_ones;
        if (borrow1)
            dec_min_ones = (min_ones == 4'd0) ? 4'd9 : min_ones - 4'd1;

        dec_min_tens = borrow2 ? min_tens - 4'd1 : min_tens;

        dec_zero = ({dec_min_tens, dec_min_ones,
                     dec_sec_tens, dec_sec_ones} == 16'h0000);
    end

    // Next-state and next-count logic
    always_comb begin
        state_n      = state;
        min_tens_n   = min_tens;
        min_ones_n   = min_ones;
        sec_tens_n   = sec_tens;
        sec_ones_n   = sec_ones;
        done_pulse_n = 1'b0;

        if (load_timer) begin
            min_tens_n = ld_min_tens;
            min_ones_n = ld_min_ones;
            sec_tens_n = ld_sec_tens;
            sec_ones_n = ld_sec_ones;
            if (ld_zero)
                state_n = ZERO;
            else if (main_timer_enable)
                state_n = RUNNING;
            else
                state_n = PAUSED;
        end else begin
            unique case (state)
                PAUSED, RUNNING: begin
                    // Enable is sampled on this edge; a pulse only counts
                    // when enable is high at the same time.
                    state_n = main_timer_enable ? RUNNING : PAUSED;
                    if (main_timer_enable && sec_pulse) begin
                        min_tens_n = dec_min_tens;
                        min_ones_n = dec_min_ones;
                        sec_tens_n = dec_sec_tens;
                        sec_ones_n = dec_sec_ones;
                        if (dec_zero) begin
                            state_n      = EXPIRED;
                            done_pulse_n = 1'b1;
                        end
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ZERO;
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            min_tens   <= min_tens_n;
            min_ones   <= min_ones_n;
            sec_tens   <= sec_tens_n;
            sec_ones   <= sec_ones_n;
            done_pulse <= done_pulse_n;
        end
    end

    // Derived from the state register, so it moves with the digits.
    assign timer_done = (state == ZERO) || (state == EXPIRED);

`ifdef COUNTDOWN_ALARM_EN
    logic [3:0] alarm_cnt, alarm_cnt_n;
    logic       alarm_n;

    always_comb begin
        alarm_n     = alarm;
        alarm_cnt_n = alarm_cnt;
        if (load_timer) begin
            alarm_n     = 1'b0;
            alarm_cnt_n = 4'd0;
        end else if (state != EXPIRED && state_n == EXPIRED) begin
            alarm_n     = 1'b1;
            alarm_cnt_n = 4'(ALARM_SECONDS);
        end else if (state == EXPIRED && sec_pulse && alarm_cnt != 4'd0) begin
            alarm_cnt_n = alarm_cnt - 4'd1;
            if (alarm_cnt == 4'd1)
                alarm_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm     <= 1'b0;
            alarm_cnt <= 4'd0;
        end else begin
            alarm     <= alarm_n;
            alarm_cnt <= alarm_cnt_n;
        end
    end
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed self-checking bench for countdown_timer.
// Covers reset, full countdown, clamping, pause, load/pulse overlap, zero load, async reset, alarm.
module tb_countdown_timer;

`ifdef COUNTDOWN_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sec_pulse;
    logic       load_timer;
    logic       main_timer_enable;
    logic [3:0] set_min_tens, set_min_ones, set_sec_tens, set_sec_ones;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done, done_pulse, alarm;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    countdown_timer #(.ALARM_SECONDS(5)) dut (
        .clk               (clk),
        .reset             (reset),
        .sec_pulse         (sec_pulse),
        .load_timer        (load_timer),
        .main_timer_enable (main_timer_enable),
        .set_min_tens      (set_min_tens),
        .set_min_ones      (set_min_ones),
        .set_sec_tens      (set_sec_tens),
        .set_sec_ones      (set_sec_ones),
        .min_tens          (min_tens),
        .min_ones          (min_ones),
        .sec_tens          (sec_tens),
        .sec_ones          (sec_ones),
        .timer_done        (timer_done),
        .done_pulse        (done_pulse),
        .alarm             (alarm)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (done_pulse) n_pulses++;

    function automatic logic [15:0] disp();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        sec_pulse = 1'b1;
        cycle();
        sec_pulse = 1'b0;
    endtask

    task automatic load(input logic [15:0] v, input logic with_pulse);
        {set_min_tens, set_min_ones, set_sec_tens, set_sec_ones} = v;
        load_timer = 1'b1;
        sec_pulse  = with_pulse;
        cycle();
        load_timer = 1'b0;
        sec_pulse  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sec_pulse = 1'b0;
        load_timer = 1'b0;
        main_timer_enable = 1'b0;
        {set_min_tens, set_min_ones, set_sec_tens, set_sec_ones} = 16'h0;
        repeat (3) cycle();
        check("rst_disp", disp(), 16'h0000);
        check("rst_done", timer_done, 1);
        check("rst_pulse", done_pulse, 0);
        check("rst_alarm", alarm, 0);
        reset = 1'b0;
        cycle();

        // Pulses in ZERO change nothing
        main_timer_enable = 1'b1;
        repeat (10) pulse();
        check("zero_hold_disp", disp(), 16'h0000);
        check("zero_hold_done", timer_done, 1);
        check("zero_hold_npulse", n_pulses, 0);

        // Full countdown from 01:05
        load(16'h0105, 1'b0);
        check("ld105_disp", disp(), 16'h0105);
        check("ld105_done", timer_done, 0);
        for (int i = 1; i <= 65; i++) begin
            pulse();
            if (i == 5)  check("s5_disp", disp(), 16'h0100);
            if (i == 6)  check("s6_disp", disp(), 16'h0059);
            if (i == 64) begin
                check("s64_disp", disp(), 16'h0001);
                check("s64_done", timer_done, 0);
                check("s64_pulse", done_pulse, 0);
            end
        end
        check("s65_disp", disp(), 16'h0000);
        check("s65_done", timer_done, 1);
        check("s65_pulse", done_pulse, 1);
        check("s65_alarm", alarm, ALARM_ON);
        cycle();
        check("post_pulse_low", done_pulse, 0);
        repeat (4) pulse();
        check("alarm_after4", alarm, ALARM_ON);
        pulse();
        check("alarm_after5", alarm, 0);
        check("exp_hold_disp", disp(), 16'h0000);
        check("exp_npulse", n_pulses, 1);

        // Clamped load 9,F,7,C -> 99:59
        load(16'h9F7C, 1'b0);
        check("clamp_disp", disp(), 16'h9959);
        pulse();
        check("clamp_dec", disp(), 16'h9958);
        check("clamp_done", timer_done, 0);

        // Pause and resume at 00:30
        load(16'h0030, 1'b0);
        check("ld30_disp", disp(), 16'h0030);
        main_timer_enable = 1'b0;
        cycle();
        repeat (5) pulse();
        check("pause_disp", disp(), 16'h0030);
        check("pause_done", timer_done, 0);
        main_timer_enable = 1'b1;
        cycle();
        pulse();
        check("resume_disp", disp(), 16'h0029);

        // Enable falling with a pulse: no decrement
        main_timer_enable = 1'b0;
        pulse();
        check("en_fall_disp", disp(), 16'h0029);
        main_timer_enable = 1'b1;
        cycle();

        // Load wins over a simultaneous pulse
        load(16'h0200, 1'b1);
        check("ld_pulse_disp", disp(), 16'h0200);

        // Zero load
        load(16'h0000, 1'b0);
        check("zld_done", timer_done, 1);
        check("zld_pulse", done_pulse, 0);
        pulse();
        check("zld_hold", disp(), 16'h0000);
        check("zld_npulse", n_pulses, 1);

        // Async reset mid-count at 00:12
        load(16'h0015, 1'b0);
        repeat (3) pulse();
        check("pre_rst_disp", disp(), 16'h0012);
        #2;
        reset = 1'b1;
        #1;
        check("arst_disp", disp(), 16'h0000);
        check("arst_done", timer_done, 1);
        cycle();
        reset = 1'b0;
        cycle();

        // Load during alarm clears it on that edge
        load(16'h0002, 1'b0);
        pulse();
        pulse();
        check("exp2_done", timer_done, 1);
        check("exp2_alarm", alarm, ALARM_ON);
        load(16'h0005, 1'b0);
        check("ld_clr_alarm", alarm, 0);
        check("ld_clr_disp", disp(), 16'h0005);
        check("final_npulse", n_pulses, 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
